seven_segment_scanner: RTL and testbench

//   Time-multiplexes a NUM_DIGITS x 4-bit hex value onto a shared 7-segment bus.

---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/seg_lz_mask.sv | 31 +++
 rtl/seven_segment_scanner.sv | 135 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path.
// Used by the digit scanner and by the downstream hex->segment decoder.
//   scan_state_t   : scanner slot phase (GUARD = all digits off, SHOW = digit lit)
//   DEF_*          : default parameter values for a 4-digit display at 12 MHz
package seven_seg_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_CLK_DIV    = 12000;
    localparam int DEF_GUARD      = 16;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blanking mask for the digit scanner.
// Built only when SEVSEG_LZB_EN is defined; otherwise this file is empty.
// Ports:
//   shadow  in  4*NUM_DIGITS  captured hex value, digit 0 = shadow[3:0]
//   mask    out NUM_DIGITS    1 = digit may be enabled; digit 0 is always allowed
`ifdef SEVSEG_LZB_EN
module seg_lz_mask
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic [4*NUM_DIGITS-1:0] shadow,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic any_above;

    // Walk from the most significant digit down; a digit is shown once any
    // nibble at its own position or above is non-zero.
    always_comb begin
        any_above = 1'b0;
        mask      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            any_above = any_above | (|shadow[4*i +: 4]);
            mask[i]   = any_above;
        end
        mask[0] = 1'b1;
    end

endmodule
`endif

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a NUM_DIGITS hex display.
// Each slot of CLK_DIV cycles starts with GUARD cycles of all digits off
// (decoder settles on the new nibble), then shows one digit.
// Optional feature: define SEVSEG_LZB_EN to enable leading-zero blanking.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   value      in   hex value to capture, digit 0 = value[3:0]
//   load       in   capture value into the shadow register
//   blank_in   in   force all digit enables low; scan keeps running
//   nibble     out  nibble of the digit owning the current slot (registered)
//   digit_en   out  one-hot active-high digit enable (registered)
//   digit_idx  out  index of the digit owning the current slot (registered)
//
// state | meaning
// GUARD | all digits off; nibble already points at the slot's digit
// SHOW  | enable of digit_idx driven (subject to blank_in and blanking mask)
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GUARD      = DEF_GUARD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          load,
    input  logic                          blank_in,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - GUARD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [4*NUM_DIGITS-1:0]   shadow_sel;
    logic [IDX_W-1:0]          idx_next;
    logic [NUM_DIGITS-1:0]     idx_onehot;
    logic [NUM_DIGITS-1:0]     entry_mask;
    logic [NUM_DIGITS-1:0]     hold_mask;
    logic                      show_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    assign idx_next   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    assign idx_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
    assign shadow_sel = shadow >> {idx_next, 2'b00};
    assign show_entry = (state == seven_seg_pkg::GUARD) && (cnt == GUARD_LAST);

`ifdef SEVSEG_LZB_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] lz_mask_q;

    seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .shadow (shadow),
        .mask   (lz_mask)
    );

    // Freeze the mask for the whole SHOW phase so a load mid-slot cannot
    // change which digits are lit before the next slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lz_mask_q <= '1;
        end else if (show_entry) begin
            lz_mask_q <= lz_mask;
        end
    end

    assign entry_mask = lz_mask;
    assign hold_mask  = lz_mask_q;
`else
    assign entry_mask = '1;
    assign hold_mask  = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= seven_seg_pkg::GUARD;
            cnt       <= '0;
            digit_idx <= '0;
            nibble    <= '0;
            digit_en  <= '0;
        end else begin
            case (state)
                seven_seg_pkg::GUARD: begin
                    if (show_entry) begin
                        state    <= seven_seg_pkg::SHOW;
                        cnt      <= '0;
                        digit_en <= blank_in ? '0 : (idx_onehot & entry_mask);
                    end else begin
                        cnt      <= cnt + 1'b1;
                        digit_en <= '0;
                    end
                end
                seven_seg_pkg::SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        // Nibble moves only here so the decoder settles
                        // while all digits are off.
                        state     <= seven_seg_pkg::GUARD;
                        cnt       <= '0;
                        digit_en  <= '0;
                        digit_idx <= idx_next;
                        nibble    <= shadow_sel[3:0];
                    end else begin
                        cnt      <= cnt + 1'b1;
                        digit_en <= blank_in ? '0 : (idx_onehot & hold_mask);
                    end
                end
                default: begin
                    state    <= seven_seg_pkg::GUARD;
                    cnt      <= '0;
                    digit_en <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (NUM_DIGITS=4, CLK_DIV=8, GUARD=2).
// A reference model derives the expected outputs from the number of clock
// edges since reset release; a monitor compares them on the falling edge.
// Define SEVSEG_LZB_EN for both bench and RTL to exercise leading-zero blanking.
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = ND * CD;

    typedef struct {
        logic [3:0] en;
        logic [1:0] idx;
        logic [3:0] nib;
    } exp_t;

    logic        clk;
    logic        rst      = 1'b1;
    logic [15:0] value    = 16'h0;
    logic        load     = 1'b0;
    logic        blank_in = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic [1:0]  digit_idx;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_n      = 0;

    seven_segment_scanner #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (CD),
        .GUARD      (GD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .blank_in  (blank_in),
        .nibble    (nibble),
        .digit_en  (digit_en),
        .digit_idx (digit_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Digit i is lit if it is digit 0 or anything from nibble i upwards is non-zero.
    function automatic logic [3:0] model_mask(input logic [15:0] sh);
        logic [3:0] m;
        m = 4'b0001;
        for (int i = 1; i < ND; i++) begin
            if ((sh >> (4 * i)) != 16'h0) m[i] = 1'b1;
        end
`ifdef SEVSEG_LZB_EN
        return m;
`else
        return m | 4'b1111;
`endif
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Reference model: slot = edges / CD, phase = edges % CD; a digit is lit
    // in phases GD..CD-1. Nibble and mask are taken from the shadow value held
    // just before the slot-start / show-start edge respectively.
    initial begin : model
        logic [15:0] m_shadow;
        logic [3:0]  m_nib;
        logic [3:0]  m_mask;
        exp_t        e;
        int          phase;
        int          d;
        m_shadow = '0;
        m_nib    = '0;
        m_mask   = 4'b1111;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n      = 0;
                m_shadow = '0;
                m_nib    = '0;
                e.en     = '0;
                e.idx    = '0;
                e.nib    = '0;
            end else begin
                m_n++;
                phase = m_n % CD;
                d     = (m_n / CD) % ND;
                if (phase == 0) m_nib = 4'(m_shadow >> (4 * d));
                if (phase == GD) m_mask = model_mask(m_shadow);
                e.idx = 2'(d);
                e.nib = m_nib;
                e.en  = (phase >= GD && !blank_in) ? ((4'b0001 << d) & m_mask) : 4'b0000;
                if (load) m_shadow = value;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares on the falling edge; an asynchronous reset between
    // edges is checked directly, before any further clock edge.
    initial begin : monitor
        exp_t e;
        logic was_clk;
        forever begin
            @(negedge clk or posedge rst);
            was_clk = clk;
            if (was_clk === 1'b1) begin
                #1;
                exp_q.delete();
                chk("async_rst_digit_en", 32'(digit_en), 32'h0);
                chk("async_rst_digit_idx", 32'(digit_idx), 32'h0);
                chk("async_rst_nibble", 32'(nibble), 32'h0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("digit_en", 32'(digit_en), 32'(e.en));
                chk("digit_idx", 32'(digit_idx), 32'(e.idx));
                chk("nibble", 32'(nibble), 32'(e.nib));
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    task automatic wait_frame_pos(input int pos);
        int k;
        k = 0;
        while ((m_n % FRAME) != pos && k < 2 * FRAME) begin
            tick(1);
            k++;
        end
        if ((m_n % FRAME) != pos) begin
            $display("FAIL wait_frame_pos: got position %0d expected %0d", m_n % FRAME, pos);
            $fatal(1, "scan position never reached");
        end
    endtask

    initial begin : stimulus
        tick(3);
        rst = 1'b0;
        tick(12);

        do_load(16'h1234);
        tick(2 * FRAME + 8);

        wait_frame_pos(12);
        do_load(16'hABCD);
        tick(2 * FRAME);

        wait_frame_pos(5);
        blank_in = 1'b1;
        tick(40);
        blank_in = 1'b0;
        tick(FRAME);

        for (int i = 0; i < 240; i++) begin
            value    = 16'($urandom);
            load     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) blank_in = ~blank_in;
            tick(1);
        end
        load     = 1'b0;
        blank_in = 1'b0;
        tick(FRAME);

        do_load(16'h0050);
        tick(2 * FRAME + 3);
        do_load(16'h0000);
        tick(2 * FRAME + 3);
        do_load(16'h1234);
        tick(FRAME);

        wait_frame_pos(19);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick(FRAME + 10);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
